// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit bridging the core to a word bus
// Splits word-crossing accesses into two aligned beats, aligns store lanes and extends load data.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_we,
  input  logic [1:0]  lsu_req_length,
  input  logic        lsu_req_signed,
  input  logic [31:0] lsu_req_address,
  input  logic [31:0] lsu_req_wdata,
  output logic        lsu_done,
  output logic        lsu_error,
  output logic [31:0] lsu_read_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  // Abort fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  len_q;
  logic [1:0]  off_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  logic [31:0] r0_q;
  logic [15:0] tmo_cnt;

  logic [3:0]  len_mask;
  logic [31:0] wd_masked;
  logic [7:0]  mask8;
  logic [63:0] wd64;
  logic [63:0] rd64;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  always_comb begin
    len_mask  = 4'b0000;
    wd_masked = 32'h0;
    case (lsu_req_length)
      2'b01: begin len_mask = 4'b0001; wd_masked = {24'h0, lsu_req_wdata[7:0]};  end
      2'b10: begin len_mask = 4'b0011; wd_masked = {16'h0, lsu_req_wdata[15:0]}; end
      2'b11: begin len_mask = 4'b1111; wd_masked = lsu_req_wdata;                end
      default: ;
    endcase
    mask8 = {4'b0000, len_mask} << lsu_req_address[1:0];
    wd64  = {32'h0, wd_masked} << {lsu_req_address[1:0], 3'b000};
  end

  // The finishing beat's data is still on bus_rdata; the low word comes from r0 only after a split.
  always_comb begin
    rd64      = (state == BEAT1) ? {bus_rdata, r0_q} : {32'h0, bus_rdata};
    rd_shift  = 32'(rd64 >> {off_q, 3'b000});
    load_data = 32'h0;
    case (len_q)
      2'b01:   load_data = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b10:   load_data = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
      2'b11:   load_data = rd_shift;
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state         <= IDLE;
      lsu_req_ready <= 1'b1;
      lsu_done      <= 1'b0;
      lsu_error     <= 1'b0;
      lsu_read_data <= 32'h0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'h0;
      bus_byte_en   <= 4'h0;
      bus_wdata     <= 32'h0;
      we_q          <= 1'b0;
      signed_q      <= 1'b0;
      len_q         <= 2'b00;
      off_q         <= 2'b00;
      be_hi_q       <= 4'h0;
      wd_hi_q       <= 32'h0;
      r0_q          <= 32'h0;
      tmo_cnt       <= 16'h0;
    end else begin
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req_valid) begin
            lsu_req_ready <= 1'b0;
            we_q          <= lsu_req_we;
            signed_q      <= lsu_req_signed;
            len_q         <= lsu_req_length;
            off_q         <= lsu_req_address[1:0];
            be_hi_q       <= mask8[7:4];
            wd_hi_q       <= wd64[63:32];
            if (lsu_req_length == 2'b00) begin
              state         <= DONE;
              lsu_done      <= 1'b1;
              lsu_error     <= 1'b0;
              lsu_read_data <= 32'h0;
            end else begin
              state       <= BEAT0;
              bus_req     <= 1'b1;
              bus_we      <= lsu_req_we;
              bus_addr    <= {lsu_req_address[31:2], 2'b00};
              bus_byte_en <= mask8[3:0];
              bus_wdata   <= wd64[31:0];
              tmo_cnt     <= 16'h0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (bus_ack) begin
            tmo_cnt <= 16'h0;
            if (state == BEAT0) r0_q <= bus_rdata;
            if (state == BEAT0 && be_hi_q != 4'h0) begin
              state       <= BEAT1;
              bus_addr    <= bus_addr + 32'd4;
              bus_byte_en <= be_hi_q;
              bus_wdata   <= wd_hi_q;
            end else begin
              state     <= DONE;
              bus_req   <= 1'b0;
              lsu_done  <= 1'b1;
              lsu_error <= 1'b0;
              if (!we_q) lsu_read_data <= load_data;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= DONE;
            bus_req       <= 1'b0;
            lsu_done      <= 1'b1;
            lsu_error     <= 1'b1;
            lsu_read_data <= 32'h0;
            tmo_cnt       <= 16'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE: begin
          state         <= IDLE;
          lsu_req_ready <= 1'b1;
          lsu_error     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
